event_arbiter: RTL and testbench
================================

EVENT_ARBITER -- requirements
Module: event_arbiter

Interface
REQ-001 Parameter N_SRC, default 4: number of event requesters (2..16).
REQ-002 Parameter DATA_W, default 32: event payload width.
REQ-003 Parameter TS_W, default 32: timestamp width.
REQ-004 Parameter CNT_W, default 16: filtered-event counter width.
REQ-005 Ports SHALL be as follows; one clock; reset is synchronous and active-high:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  N_SRC  per-source event request
- req_ready  out  N_SRC  per-source acceptance, one-hot or zero
- req_level  in  3*N_SRC  per-source severity: 0 TRACE, 1 DEBUG, 2 INFO, 3 WARN, 4 ERROR, 5 FATAL, 6-7 treated as FATAL
- req_data  in  DATA_W*N_SRC  per-source payload
- min_level  in  3  severity threshold for filtering
- evt_valid  out  1  output event present
- evt_ready  in  1  sink accepts output event
- evt_src  out  clog2(N_SRC)  index of the originating source
- evt_level  out  3  severity of the output event
- evt_data  out  DATA_W  payload of the output event
- evt_time  out  TS_W  timestamp of the output event
- filt_count  out  CNT_W  number of filtered events, saturating
- fatal_seen  out  1  sticky flag for an emitted FATAL event

Function
REQ-006 Free-running counter ts SHALL hold 0 in the first cycle after rst deasserts, increment by 1 each cycle, and wrap from 2^TS_W-1 to 0.
REQ-007 Grant opportunity SHALL exist in a cycle iff evt_valid=0, or evt_valid=1 and evt_ready=1.
REQ-008 At a grant opportunity with any req_valid high, exactly one source SHALL be granted, selected round-robin: the first valid source searching upward from ptr+1 (mod N_SRC), where ptr is the last granted index.
REQ-009 req_ready SHALL be combinational and high only for the granted source in the granting cycle; otherwise it SHALL be 0.
REQ-010 A source SHALL hold req_valid, req_level and req_data stable until req_ready; the block SHALL NOT drop or duplicate an accepted request.
REQ-011 On a grant, ptr SHALL update to the granted index at the next edge, whether or not the event is filtered.
REQ-012 Granted event with req_level >= min_level (unsigned compare, 6-7 as 5) SHALL load the output register at the next edge: evt_valid=1 and evt_src/level/data set, with evt_time = ts of the granting cycle.
REQ-013 Granted event with req_level < min_level SHALL be filtered. It is accepted and not emitted. filt_count increments by 1 and saturates at 2^CNT_W-1. evt_valid takes the value it would have with no grant.
REQ-014 Output state machine: EMPTY (evt_valid=0) and FULL (evt_valid=1).
- EMPTY -> FULL on an unfiltered grant.
- FULL -> FULL on evt_ready with an unfiltered grant (back-to-back reload, one event per cycle).
- FULL -> EMPTY on evt_ready with no unfiltered grant.
- FULL holds on evt_ready=0.
REQ-015 While FULL and evt_ready=0, evt_src/level/data/time SHALL remain stable and no req_ready SHALL assert.
REQ-016 Latency SHALL be 1 cycle from grant to evt_valid; sustained throughput SHALL be one event per cycle while evt_ready=1.
REQ-017 fatal_seen SHALL set on the edge where an event with level >= 5 loads the output register, and remain set until rst.
REQ-018 min_level SHALL be sampled in the grant cycle; changing it SHALL NOT affect an event already in the output register.
REQ-019 With min_level=0, no event SHALL be filtered. With all req_valid low, state SHALL be unchanged apart from ts.

Reset
REQ-020 rst=1 at an edge SHALL set evt_valid=0, ptr=N_SRC-1 (source 0 gets first priority), ts=0, filt_count=0, fatal_seen=0.
REQ-021 req_ready SHALL be 0 in any cycle with rst=1.
REQ-022 An event held in the output register at reset SHALL be discarded; evt_* data fields are don't-care while evt_valid=0.

Verification
REQ-023 Round-robin: N_SRC=4, all req_valid=1 continuously, evt_ready=1, min_level=0 -> evt_src sequence 0,1,2,3,0,... one per cycle, with evt_time consecutive.
REQ-024 Backpressure: single source 2 valid, evt_ready=0 for 5 cycles -> evt_valid held, fields stable, req_ready=0 after the first grant; the queued request is accepted on the cycle evt_ready=1.
REQ-025 Filtering: min_level=3; source 0 sends level 1, then source 1 sends level 4 -> filt_count=1; only source 1's event is emitted, at level 4; req_ready pulsed once for each source.
REQ-026 Saturation and wrap: CNT_W=2, 5 filtered events -> filt_count=3. TS_W=4: an event granted at ts=15 and the next at ts=0 are stamped 15 then 0.
REQ-027 FATAL: level 6 event emitted -> evt_level=6 and fatal_seen=1; fatal_seen persists after subsequent INFO events and clears only on rst.
REQ-028 Reset mid-operation: evt_valid=1, evt_ready=0, rst=1 for one cycle -> evt_valid=0, filt_count=0, ts=0; the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/event_arbiter_if.sv
// Event arbiter bus: per-source request handshakes, output event stream, status.
// Pure wiring, no latency of its own.
// Requests and the event stream use valid/ready; status signals are free-running.
interface event_arbiter_if #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 32,
  parameter int TS_W   = 32,
  parameter int CNT_W  = 16
);
  localparam int SRC_W = $clog2(N_SRC);

  logic [N_SRC-1:0]        req_valid;
  logic [N_SRC-1:0]        req_ready;
  logic [3*N_SRC-1:0]      req_level;
  logic [DATA_W*N_SRC-1:0] req_data;
  logic [2:0]              min_level;
  logic                    evt_valid;
  logic                    evt_ready;
  logic [SRC_W-1:0]        evt_src;
  logic [2:0]              evt_level;
  logic [DATA_W-1:0]       evt_data;
  logic [TS_W-1:0]         evt_time;
  logic [CNT_W-1:0]        filt_count;
  logic                    fatal_seen;

  // Arbiter side
  modport slave (
    input  req_valid, req_level, req_data, min_level, evt_ready,
    output req_ready, evt_valid, evt_src, evt_level, evt_data, evt_time,
           filt_count, fatal_seen
  );

  // Requester / sink side
  modport master (
    output req_valid, req_level, req_data, min_level, evt_ready,
    input  req_ready, evt_valid, evt_src, evt_level, evt_data, evt_time,
           filt_count, fatal_seen
  );
endinterface

// File: rtl/event_arbiter.sv
// Round-robin event arbiter with severity filter, timestamping and sticky FATAL flag.
// Latency: 1 cycle from grant (req_ready) to evt_valid; one event per cycle sustained.
// Backpressure: while the output register is full and evt_ready=0, no request is granted.
module event_arbiter #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 32,
  parameter int TS_W   = 32,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           rst,
  event_arbiter_if.slave bus
);
  localparam int              SRC_W = $clog2(N_SRC);
  localparam logic [SRC_W:0]  N_EXT = (SRC_W+1)'(N_SRC);
  localparam logic [0:0]      ST_EMPTY = 1'b0;
  localparam logic [0:0]      ST_FULL  = 1'b1;

  // Levels 6 and 7 behave as FATAL (5) for every comparison.
  function automatic logic [2:0] clamp_lvl(input logic [2:0] l);
    return (l > 3'd5) ? 3'd5 : l;
  endfunction

  logic [0:0]        state;
  logic [SRC_W-1:0]  ptr;
  logic [TS_W-1:0]   ts;
  logic [CNT_W-1:0]  filt_cnt;
  logic              fatal_q;

  logic [SRC_W-1:0]  evt_src_q;
  logic [2:0]        evt_level_q;
  logic [DATA_W-1:0] evt_data_q;
  logic [TS_W-1:0]   evt_time_q;

  logic              opp;
  logic              gnt_any;
  logic              grant;
  logic              pass;
  logic [SRC_W-1:0]  gnt_idx;
  logic [SRC_W:0]    cand;
  logic [2:0]        sel_lvl;
  logic [DATA_W-1:0] sel_dat;

  // A new event can be taken when the output register is empty or drains this cycle.
  assign opp = (state == ST_EMPTY) || bus.evt_ready;

  // Round-robin search: first valid source upward from ptr+1, wrapping at N_SRC.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cand = {1'b0, ptr} + (SRC_W+1)'(i) + (SRC_W+1)'(1);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!gnt_any && bus.req_valid[cand[SRC_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[SRC_W-1:0];
      end
    end
  end

  assign grant   = opp && gnt_any && !rst;
  assign sel_lvl = bus.req_level[int'(gnt_idx)*3 +: 3];
  assign sel_dat = bus.req_data[int'(gnt_idx)*DATA_W +: DATA_W];
  assign pass    = clamp_lvl(sel_lvl) >= clamp_lvl(bus.min_level);

  // One-hot acceptance for the granted source only, in the granting cycle.
  always_comb begin
    bus.req_ready = '0;
    for (int j = 0; j < N_SRC; j++) begin
      bus.req_ready[j] = grant && (gnt_idx == SRC_W'(j));
    end
  end

  // Control state: output FSM, pointer, timestamp, filter counter, sticky FATAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      ptr      <= SRC_W'(N_SRC-1);
      ts       <= '0;
      filt_cnt <= '0;
      fatal_q  <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      if (grant) ptr <= gnt_idx;
      if (grant && !pass && (filt_cnt != '1)) filt_cnt <= filt_cnt + CNT_W'(1);
      if (grant && pass && (clamp_lvl(sel_lvl) == 3'd5)) fatal_q <= 1'b1;
      case (state)
        ST_EMPTY: if (grant && pass) state <= ST_FULL;
        ST_FULL:  if (bus.evt_ready && !(grant && pass)) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  // Output payload register; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk) begin
    if (grant && pass) begin
      evt_src_q   <= gnt_idx;
      evt_level_q <= sel_lvl;
      evt_data_q  <= sel_dat;
      evt_time_q  <= ts;
    end
  end

  assign bus.evt_valid  = (state == ST_FULL);
  assign bus.evt_src    = evt_src_q;
  assign bus.evt_level  = evt_level_q;
  assign bus.evt_data   = evt_data_q;
  assign bus.evt_time   = evt_time_q;
  assign bus.filt_count = filt_cnt;
  assign bus.fatal_seen = fatal_q;
endmodule

// File: tb/tb_event_arbiter.sv
// Directed bench for event_arbiter: round-robin, backpressure, filtering,
// saturation, timestamp wrap, FATAL stickiness and mid-operation reset.
// Small TS_W/CNT_W so saturation and wrap are reached quickly.
module tb_event_arbiter;
  localparam int N_SRC  = 4;
  localparam int DATA_W = 32;
  localparam int TS_W   = 4;
  localparam int CNT_W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  event_arbiter_if #(.N_SRC(N_SRC), .DATA_W(DATA_W), .TS_W(TS_W), .CNT_W(CNT_W)) bus ();

  event_arbiter #(.N_SRC(N_SRC), .DATA_W(DATA_W), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference timestamp: value of ts during the current cycle.
  logic [TS_W-1:0] ts_m;
  always @(posedge clk) begin
    if (rst) ts_m <= '0;
    else     ts_m <= ts_m + TS_W'(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [2:0] lvl, input logic [31:0] d);
    bus.req_level[s*3 +: 3]       = lvl;
    bus.req_data[s*DATA_W +: DATA_W] = d;
  endtask

  logic [TS_W-1:0] t_a;
  logic [TS_W-1:0] t_b;

  initial begin
    bus.req_valid = '0;
    bus.req_level = '0;
    bus.req_data  = '0;
    bus.min_level = 3'd0;
    bus.evt_ready = 1'b0;
    for (int s = 0; s < N_SRC; s++) set_src(s, 3'd2, 32'hD0 + 32'(s));

    // Reset state, and no acceptance while rst is high
    tick();
    tick();
    bus.req_valid = 4'hF;
    #1;
    check_eq("rst_ready", 64'(bus.req_ready), 64'h0);
    check_eq("rst_valid", 64'(bus.evt_valid), 64'h0);
    check_eq("rst_filt", 64'(bus.filt_count), 64'h0);
    check_eq("rst_fatal", 64'(bus.fatal_seen), 64'h0);

    // Round-robin with all sources valid: 0,1,2,3,0,... stamped 0,1,2,...
    rst = 1'b0;
    bus.evt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check_eq("rr_ready", 64'(bus.req_ready), 64'(1) << (k % 4));
      tick();
      check_eq("rr_valid", 64'(bus.evt_valid), 64'h1);
      check_eq("rr_src", 64'(bus.evt_src), 64'(k % 4));
      check_eq("rr_time", 64'(bus.evt_time), 64'(k));
      check_eq("rr_data", 64'(bus.evt_data), 64'h0D0 + 64'(k % 4));
    end
    bus.req_valid = '0;
    tick();
    check_eq("rr_drain", 64'(bus.evt_valid), 64'h0);

    // Backpressure: source 2 alone, sink stalls for 5 cycles
    bus.evt_ready = 1'b0;
    bus.req_valid = 4'b0100;
    set_src(2, 3'd2, 32'hB1);
    #1;
    check_eq("bp_first_ready", 64'(bus.req_ready), 64'h4);
    t_a = ts_m;
    tick();
    check_eq("bp_first_valid", 64'(bus.evt_valid), 64'h1);
    set_src(2, 3'd2, 32'hB2);
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("bp_hold_ready", 64'(bus.req_ready), 64'h0);
      check_eq("bp_hold_valid", 64'(bus.evt_valid), 64'h1);
      check_eq("bp_hold_src", 64'(bus.evt_src), 64'h2);
      check_eq("bp_hold_data", 64'(bus.evt_data), 64'hB1);
      check_eq("bp_hold_time", 64'(bus.evt_time), 64'(t_a));
      tick();
    end
    bus.evt_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 64'(bus.req_ready), 64'h4);
    t_b = ts_m;
    tick();
    check_eq("bp_second_data", 64'(bus.evt_data), 64'hB2);
    check_eq("bp_second_time", 64'(bus.evt_time), 64'(t_b));
    bus.req_valid = '0;
    tick();
    check_eq("bp_drain", 64'(bus.evt_valid), 64'h0);

    // Filtering: threshold WARN; DEBUG from src 0 dropped, ERROR from src 1 emitted
    bus.min_level = 3'd3;
    bus.req_valid = 4'b0001;
    set_src(0, 3'd1, 32'hF0);
    #1;
    check_eq("flt_ready0", 64'(bus.req_ready), 64'h1);
    tick();
    check_eq("flt_valid0", 64'(bus.evt_valid), 64'h0);
    check_eq("flt_count1", 64'(bus.filt_count), 64'h1);
    bus.req_valid = 4'b0010;
    set_src(1, 3'd4, 32'hF1);
    #1;
    check_eq("flt_ready1", 64'(bus.req_ready), 64'h2);
    tick();
    check_eq("flt_valid1", 64'(bus.evt_valid), 64'h1);
    check_eq("flt_src1", 64'(bus.evt_src), 64'h1);
    check_eq("flt_level1", 64'(bus.evt_level), 64'h4);
    check_eq("flt_data1", 64'(bus.evt_data), 64'hF1);
    check_eq("flt_count_keep", 64'(bus.filt_count), 64'h1);
    bus.req_valid = '0;
    tick();

    // Saturation: four more TRACE events from src 0 -> 2, 3, 3, 3
    set_src(0, 3'd0, 32'h50);
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("sat_ready", 64'(bus.req_ready), 64'h1);
      tick();
      check_eq("sat_count", 64'(bus.filt_count), (k == 0) ? 64'h2 : 64'h3);
      check_eq("sat_valid", 64'(bus.evt_valid), 64'h0);
    end
    bus.req_valid = '0;
    bus.min_level = 3'd0;
    tick();

    // Timestamp wrap: grants at ts=15 then ts=0
    for (int w = 0; w < 20 && ts_m != 4'd15; w++) tick();
    bus.req_valid = 4'b0001;
    set_src(0, 3'd2, 32'hE0);
    tick();
    check_eq("wrap_t15", 64'(bus.evt_time), 64'd15);
    set_src(0, 3'd2, 32'hE1);
    tick();
    check_eq("wrap_t0", 64'(bus.evt_time), 64'd0);
    check_eq("wrap_data", 64'(bus.evt_data), 64'hE1);
    bus.req_valid = '0;
    tick();

    // FATAL (level 6) then INFO: flag is sticky
    check_eq("fatal_pre", 64'(bus.fatal_seen), 64'h0);
    bus.req_valid = 4'b1000;
    set_src(3, 3'd6, 32'hA6);
    tick();
    check_eq("fatal_level", 64'(bus.evt_level), 64'h6);
    check_eq("fatal_set", 64'(bus.fatal_seen), 64'h1);
    set_src(3, 3'd2, 32'hA2);
    tick();
    check_eq("fatal_info_level", 64'(bus.evt_level), 64'h2);
    check_eq("fatal_sticky", 64'(bus.fatal_seen), 64'h1);
    bus.req_valid = '0;
    tick();
    check_eq("fatal_sticky_idle", 64'(bus.fatal_seen), 64'h1);

    // Reset mid-operation with a stalled event in the output register
    bus.evt_ready = 1'b0;
    bus.req_valid = 4'b0100;
    set_src(2, 3'd2, 32'hC2);
    tick();
    check_eq("mid_full", 64'(bus.evt_valid), 64'h1);
    bus.req_valid = 4'b1010;
    set_src(1, 3'd2, 32'hC1);
    set_src(3, 3'd2, 32'hC3);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ready", 64'(bus.req_ready), 64'h0);
    tick();
    check_eq("mid_valid", 64'(bus.evt_valid), 64'h0);
    check_eq("mid_filt", 64'(bus.filt_count), 64'h0);
    check_eq("mid_fatal", 64'(bus.fatal_seen), 64'h0);
    rst = 1'b0;
    #1;
    check_eq("mid_ready_lowest", 64'(bus.req_ready), 64'h2);
    tick();
    check_eq("mid_src", 64'(bus.evt_src), 64'h1);
    check_eq("mid_time", 64'(bus.evt_time), 64'h0);
    check_eq("mid_data", 64'(bus.evt_data), 64'hC1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
